// File: rtl/controlador_contexto_regs_pkg.sv
// Shared definitions for the register-context save/restore sequencer:
// state encoding, slot layout constants and the port command payloads.
package controlador_contexto_regs_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned NUM_SALVOS   = 31;
  localparam int unsigned SLOT_PC      = 31;
  localparam int unsigned ZERO_REG     = 31;
  localparam int unsigned REG_FP       = 29;
  localparam int unsigned IDX_FIM_REST = 32;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    SALVA    = 3'd1,
    SALVA_PC = 3'd2,
    RESTAURA = 3'd3,
    FIM      = 3'd4
  } estado_t;

  // Data-memory command issued by the sequencer in one cycle.
  typedef struct packed {
    logic [DATA_W-1:0] endereco;
    logic              escreve;
    logic              le;
    logic [DATA_W-1:0] dado;
  } mem_cmd_t;

  // Register-bank write command issued by the sequencer in one cycle.
  typedef struct packed {
    logic [REG_W-1:0]  indice;
    logic              escreve;
    logic [DATA_W-1:0] dado;
  } banco_cmd_t;

  // Word address of a save slot; idx is zero-extended and the add wraps mod 2^32.
  function automatic logic [DATA_W-1:0] end_slot(input logic [DATA_W-1:0] base,
                                                 input logic [IDX_W-1:0]  idx);
    return base + DATA_W'(idx);
  endfunction

endpackage

// File: rtl/controlador_contexto_regs_if.sv
// Port bundle between the context sequencer, the register bank, data memory
// and the interrupt/pipeline logic.
interface controlador_contexto_regs_if;
  import controlador_contexto_regs_pkg::*;

  logic              SalvaReq;
  logic              RestauraReq;
  logic [DATA_W-1:0] PCAtual;
  logic              Ocupado;
  logic              Pronto;
  logic [REG_W-1:0]  RegLeitura;
  logic [DATA_W-1:0] DadoLido;
  logic [REG_W-1:0]  RegEscrita;
  logic              RegWrite;
  logic [DATA_W-1:0] EscreveDado;
  logic [DATA_W-1:0] MemEnd;
  logic              MemEscreve;
  logic              MemLe;
  logic [DATA_W-1:0] MemDadoEscrita;
  logic [DATA_W-1:0] MemDadoLido;
  logic [DATA_W-1:0] PCRestaurado;
  logic              PCValido;

  modport master (
    input  SalvaReq, RestauraReq, PCAtual, DadoLido, MemDadoLido,
    output Ocupado, Pronto, RegLeitura, RegEscrita, RegWrite, EscreveDado,
           MemEnd, MemEscreve, MemLe, MemDadoEscrita, PCRestaurado, PCValido
  );

  modport slave (
    output SalvaReq, RestauraReq, PCAtual, DadoLido, MemDadoLido,
    input  Ocupado, Pronto, RegLeitura, RegEscrita, RegWrite, EscreveDado,
           MemEnd, MemEscreve, MemLe, MemDadoEscrita, PCRestaurado, PCValido
  );

endinterface

// File: rtl/controlador_contexto_regs.sv
// Context save/restore sequencer: streams registers 0..30 and the PC to
// consecutive memory slots on save, and streams them back on restore.
module controlador_contexto_regs #(
  parameter logic [31:0] SAVE_BASE = 32'h0000_0100,
  parameter int unsigned ZERO_REG  = 31
) (
  input  logic                          Clock,
  input  logic                          Reset,
  controlador_contexto_regs_if.master   bus
);
  import controlador_contexto_regs_pkg::*;

  estado_t           estado, estado_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] pc_rest, pc_rest_n;
  logic              veio_restaura, veio_restaura_n;

  mem_cmd_t          mem_c;
  banco_cmd_t        banco_c;
  logic [REG_W-1:0]  reg_leitura_c;
  logic [REG_W-1:0]  reg_alvo_c;
  logic              pronto_c;
  logic              pc_valido_c;

  // State, slot index and recovered PC
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado        <= OCIOSO;
      idx           <= '0;
      pc_rest       <= '0;
      veio_restaura <= 1'b0;
    end else begin
      estado        <= estado_n;
      idx           <= idx_n;
      pc_rest       <= pc_rest_n;
      veio_restaura <= veio_restaura_n;
    end
  end

  // Next state and per-state port commands
  always_comb begin
    estado_n        = estado;
    idx_n           = idx;
    pc_rest_n       = pc_rest;
    veio_restaura_n = veio_restaura;
    mem_c           = '0;
    banco_c         = '0;
    reg_leitura_c   = '0;
    pronto_c        = 1'b0;
    pc_valido_c     = 1'b0;
    // Restore writes lag the memory read by one cycle, hence idx-1.
    reg_alvo_c      = REG_W'(idx - IDX_W'(1));

    unique case (estado)
      OCIOSO: begin
        veio_restaura_n = 1'b0;
        if (bus.SalvaReq) begin
          estado_n = SALVA;
          idx_n    = '0;
        end else if (bus.RestauraReq) begin
          estado_n = RESTAURA;
          idx_n    = '0;
        end
      end

      SALVA: begin
        reg_leitura_c = REG_W'(idx);
        if (REG_W'(idx) != REG_W'(ZERO_REG)) begin
          mem_c.endereco = end_slot(SAVE_BASE, idx);
          mem_c.escreve  = 1'b1;
          mem_c.dado     = bus.DadoLido;
        end
        if (idx == IDX_W'(NUM_SALVOS - 1)) begin
          estado_n = SALVA_PC;
          idx_n    = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end

      SALVA_PC: begin
        mem_c.endereco = end_slot(SAVE_BASE, IDX_W'(SLOT_PC));
        mem_c.escreve  = 1'b1;
        mem_c.dado     = bus.PCAtual;
        estado_n       = FIM;
      end

      RESTAURA: begin
        if (idx <= IDX_W'(SLOT_PC)) begin
          mem_c.endereco = end_slot(SAVE_BASE, idx);
          mem_c.le       = 1'b1;
        end
        if ((idx != '0) && (idx <= IDX_W'(NUM_SALVOS)) &&
            (reg_alvo_c != REG_W'(ZERO_REG))) begin
          banco_c.indice  = reg_alvo_c;
          banco_c.escreve = 1'b1;
          banco_c.dado    = bus.MemDadoLido;
        end
        if (idx == IDX_W'(IDX_FIM_REST)) begin
          pc_rest_n       = bus.MemDadoLido;
          veio_restaura_n = 1'b1;
          estado_n        = FIM;
          idx_n           = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end

      FIM: begin
        pronto_c    = 1'b1;
        pc_valido_c = veio_restaura;
        estado_n    = OCIOSO;
      end

      default: begin
        estado_n = OCIOSO;
        idx_n    = '0;
      end
    endcase
  end

  assign bus.Ocupado        = (estado != OCIOSO);
  assign bus.Pronto         = pronto_c;
  assign bus.PCValido       = pc_valido_c;
  assign bus.PCRestaurado   = pc_rest;
  assign bus.RegLeitura     = reg_leitura_c;
  assign bus.RegEscrita     = banco_c.indice;
  assign bus.RegWrite       = banco_c.escreve;
  assign bus.EscreveDado    = banco_c.dado;
  assign bus.MemEnd         = mem_c.endereco;
  assign bus.MemEscreve     = mem_c.escreve;
  assign bus.MemLe          = mem_c.le;
  assign bus.MemDadoEscrita = mem_c.dado;

endmodule
